// File: rtl/read_data_control.sv
// Receive-side buffer-write assembler: checks tag/data parity on each 512-bit half-line beat
// and emits one 1024-bit line per tag once both halves have been seen.
module read_data_control #(
    parameter int TAG_DEPTH  = 256,
    parameter int HALF_WIDTH = 512
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      enabled_in,
    input  logic                      bw_valid,
    input  logic [7:0]                bw_tag,
    input  logic                      bw_tag_parity,
    input  logic [5:0]                bw_address,
    input  logic [HALF_WIDTH-1:0]     bw_data,
    input  logic [HALF_WIDTH/64-1:0]  bw_parity,
    input  logic                      tag_clear_valid,
    input  logic [7:0]                tag_clear_tag,
    output logic                      data_valid_out,
    output logic [7:0]                data_tag_out,
    output logic [2*HALF_WIDTH-1:0]   data_out,
    output logic [1:0]                data_read_error
);

    localparam int DW_COUNT = HALF_WIDTH / 64;

    logic                     enabled;
    logic                     s1_valid;
    logic [7:0]               s1_tag;
    logic                     s1_tag_parity;
    logic                     s1_half;
    logic [HALF_WIDTH-1:0]    s1_data;
    logic [DW_COUNT-1:0]      s1_parity;

    logic [TAG_DEPTH-1:0]     seen0;
    logic [TAG_DEPTH-1:0]     seen1;
    logic [HALF_WIDTH-1:0]    ram0 [TAG_DEPTH];
    logic [HALF_WIDTH-1:0]    ram1 [TAG_DEPTH];

    logic                     s2_complete;
    logic [7:0]               s2_tag;
    logic                     s2_half;
    logic [HALF_WIDTH-1:0]    s2_cur;
    logic [HALF_WIDTH-1:0]    s2_opp;

    logic [DW_COUNT-1:0]      dw_parity;
    logic                     tag_err;
    logic                     data_err;
    logic                     clear_hit;
    logic                     opp_seen;
    logic                     complete;

    // Stage 1: input register; beats are dropped while the registered enable is low.
    always_ff @(posedge clock) begin
        if (rst) begin
            enabled  <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            enabled  <= enabled_in;
            s1_valid <= bw_valid && enabled;
            if (bw_valid && enabled) begin
                s1_tag        <= bw_tag;
                s1_tag_parity <= bw_tag_parity;
                s1_half       <= |bw_address;
                s1_data       <= bw_data;
                s1_parity     <= bw_parity;
            end
        end
    end

    always_comb begin
        dw_parity = '0;
        for (int i = 0; i < DW_COUNT; i++) begin
            dw_parity[i] = ~^s1_data[64*i +: 64];
        end
        tag_err   = (~^s1_tag) ^ s1_tag_parity;
        data_err  = |(dw_parity ^ s1_parity);
        clear_hit = tag_clear_valid && (tag_clear_tag == s1_tag);
        opp_seen  = s1_half ? seen0[s1_tag] : seen1[s1_tag];
        complete  = s1_valid && opp_seen && !clear_hit;
    end

    // A clear of the beat's own tag suppresses both the seen update and completion.
    always_ff @(posedge clock) begin
        if (rst) begin
            seen0 <= '0;
            seen1 <= '0;
        end else begin
            if (s1_valid && !clear_hit) begin
                if (opp_seen) begin
                    seen0[s1_tag] <= 1'b0;
                    seen1[s1_tag] <= 1'b0;
                end else if (s1_half) begin
                    seen1[s1_tag] <= 1'b1;
                end else begin
                    seen0[s1_tag] <= 1'b1;
                end
            end
            if (tag_clear_valid) begin
                seen0[tag_clear_tag] <= 1'b0;
                seen1[tag_clear_tag] <= 1'b0;
            end
        end
    end

    // The previous beat's write lands on the edge before this read, so the registered
    // opposite-half read already observes it: back-to-back halves bypass through the array.
    always_ff @(posedge clock) begin
        if (s1_valid) begin
            if (s1_half) begin
                ram1[s1_tag] <= s1_data;
                s2_opp       <= ram0[s1_tag];
            end else begin
                ram0[s1_tag] <= s1_data;
                s2_opp       <= ram1[s1_tag];
            end
            s2_tag  <= s1_tag;
            s2_half <= s1_half;
            s2_cur  <= s1_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            s2_complete     <= 1'b0;
            data_read_error <= 2'b00;
        end else begin
            s2_complete     <= complete;
            data_read_error <= s1_valid ? {data_err, tag_err} : 2'b00;
        end
    end

    // Stage 3: half 0 occupies the low bits of the assembled line.
    always_ff @(posedge clock) begin
        if (rst) begin
            data_valid_out <= 1'b0;
            data_tag_out   <= '0;
            data_out       <= '0;
        end else if (s2_complete) begin
            data_valid_out <= 1'b1;
            data_tag_out   <= s2_tag;
            data_out       <= s2_half ? {s2_cur, s2_opp} : {s2_opp, s2_cur};
        end else begin
            data_valid_out <= 1'b0;
            data_tag_out   <= '0;
            data_out       <= '0;
        end
    end

endmodule

// File: tb/tb_read_data_control.sv
// Directed bench for read_data_control: stimulus pushes expected lines/errors into queues,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_read_data_control;

    logic          clock;
    logic          rst;
    logic          enabled_in;
    logic          bw_valid;
    logic [7:0]    bw_tag;
    logic          bw_tag_parity;
    logic [5:0]    bw_address;
    logic [511:0]  bw_data;
    logic [7:0]    bw_parity;
    logic          tag_clear_valid;
    logic [7:0]    tag_clear_tag;
    logic          data_valid_out;
    logic [7:0]    data_tag_out;
    logic [1023:0] data_out;
    logic [1:0]    data_read_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // {due[31:0], tag[7:0], line[1023:0]} and {due[31:0], err[1:0]}
    logic [1063:0] exp_q[$];
    logic [33:0]   err_q[$];

    read_data_control dut (
        .clock           (clock),
        .rst             (rst),
        .enabled_in      (enabled_in),
        .bw_valid        (bw_valid),
        .bw_tag          (bw_tag),
        .bw_tag_parity   (bw_tag_parity),
        .bw_address      (bw_address),
        .bw_data         (bw_data),
        .bw_parity       (bw_parity),
        .tag_clear_valid (tag_clear_valid),
        .tag_clear_tag   (tag_clear_tag),
        .data_valid_out  (data_valid_out),
        .data_tag_out    (data_tag_out),
        .data_out        (data_out),
        .data_read_error (data_read_error)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [511:0] pat(input logic [31:0] x);
        return {16{x}};
    endfunction

    function automatic logic [7:0] good_par(input logic [511:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ~^d[64*i +: 64];
        return p;
    endfunction

    task automatic drive(input logic bv, input logic [7:0] tag, input logic [5:0] addr,
                         input logic [511:0] d, input logic tflip, input logic [7:0] pflip,
                         input logic cv, input logic [7:0] ctag);
        @(posedge clock);
        #1;
        bw_valid        = bv;
        bw_tag          = tag;
        bw_address      = addr;
        bw_data         = d;
        bw_tag_parity   = (~^tag) ^ tflip;
        bw_parity       = good_par(d) ^ pflip;
        tag_clear_valid = cv;
        tag_clear_tag   = ctag;
        if (bv && (tflip || pflip != 8'h00))
            err_q.push_back({cyc + 2, |pflip, tflip});
    endtask

    task automatic send(input logic [7:0] tag, input logic [5:0] addr, input logic [511:0] d);
        drive(1'b1, tag, addr, d, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 6'd0, '0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Call right after the completing beat was driven.
    task automatic expect_line(input logic [7:0] tag, input logic [511:0] h0, input logic [511:0] h1);
        exp_q.push_back({cyc + 3, tag, h1, h0});
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (data_valid_out !== 1'b0 || data_tag_out !== 8'h00 || data_out !== '0 || data_read_error !== 2'b00) begin
            failures++;
            $display("FAIL %s: valid=%b tag=%h err=%b data_nonzero=%b required all zero",
                     name, data_valid_out, data_tag_out, data_read_error, |data_out);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [1063:0] e;
        logic [33:0]   ee;
        logic [1:0]    exp_err;
        while (exp_q.size() > 0 && exp_q[0][1063:1032] < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL line_missing: tag=%h due cycle %0d, no data_valid_out seen", e[1031:1024], e[1063:1032]);
        end
        if (data_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL line_unexpected: tag=%h at cycle %0d, none required", data_tag_out, cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (e[1063:1032] != cyc) begin
                    failures++;
                    $display("FAIL line_timing: cycle %0d required %0d", cyc, e[1063:1032]);
                end
                checks++;
                if (data_tag_out !== e[1031:1024]) begin
                    failures++;
                    $display("FAIL line_tag: got %h required %h", data_tag_out, e[1031:1024]);
                end
                checks++;
                if (data_out[511:0] !== e[511:0]) begin
                    failures++;
                    $display("FAIL line_half0 tag %h: got %h required %h", e[1031:1024], data_out[511:0], e[511:0]);
                end
                checks++;
                if (data_out[1023:512] !== e[1023:512]) begin
                    failures++;
                    $display("FAIL line_half1 tag %h: got %h required %h", e[1031:1024], data_out[1023:512], e[1023:512]);
                end
            end
        end else begin
            checks++;
            if (data_tag_out !== 8'h00 || data_out !== '0) begin
                failures++;
                $display("FAIL idle_zero: tag=%h data_nonzero=%b required zero", data_tag_out, |data_out);
            end
        end
        exp_err = 2'b00;
        if (err_q.size() > 0 && err_q[0][33:2] <= cyc) begin
            ee = err_q.pop_front();
            exp_err = ee[1:0];
            if (ee[33:2] != cyc) begin
                checks++;
                failures++;
                $display("FAIL err_timing: expected error due cycle %0d not matched", ee[33:2]);
            end
        end
        if (exp_err != 2'b00 || data_read_error !== 2'b00) begin
            checks++;
            if (data_read_error !== exp_err) begin
                failures++;
                $display("FAIL read_error at cycle %0d: got %b required %b", cyc, data_read_error, exp_err);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] aa;
        logic [511:0] ff;
        rst = 1'b1; enabled_in = 1'b0; bw_valid = 1'b0; bw_tag = '0; bw_tag_parity = 1'b0;
        bw_address = '0; bw_data = '0; bw_parity = '0; tag_clear_valid = 1'b0; tag_clear_tag = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset_outputs");
        @(posedge clock); #1;
        rst = 1'b0;
        enabled_in = 1'b1;
        idle(2);

        // Single line, gap of one cycle between halves
        aa = {64{8'hAA}};
        send(8'h05, 6'd0, aa);
        idle(1);
        send(8'h05, 6'd1, {64{8'h55}});
        expect_line(8'h05, aa, {64{8'h55}});
        idle(5);

        // Back-to-back, reversed order
        send(8'h10, 6'd32, pat(32'h1111_0001));
        send(8'h10, 6'd0, pat(32'h2222_0002));
        expect_line(8'h10, pat(32'h2222_0002), pat(32'h1111_0001));
        idle(5);

        // Interleaved tags
        send(8'h01, 6'd0, pat(32'h0101_0000));
        send(8'h02, 6'd0, pat(32'h0202_0000));
        send(8'h02, 6'd1, pat(32'h0202_1111));
        expect_line(8'h02, pat(32'h0202_0000), pat(32'h0202_1111));
        send(8'h01, 6'd1, pat(32'h0101_1111));
        expect_line(8'h01, pat(32'h0101_0000), pat(32'h0101_1111));
        idle(5);

        // Tag parity error on h0, dw3 parity error on h1; still assembled
        drive(1'b1, 8'h7F, 6'd0, pat(32'hDEAD_BEEF), 1'b1, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 8'h7F, 6'd1, pat(32'hCAFE_F00D), 1'b0, 8'h08, 1'b0, 8'h00);
        expect_line(8'h7F, pat(32'hDEAD_BEEF), pat(32'hCAFE_F00D));
        idle(5);

        // Duplicate half overwrites, no emission until the other half
        send(8'h40, 6'd0, pat(32'h4040_0000));
        send(8'h40, 6'd0, pat(32'h4040_AAAA));
        idle(3);
        send(8'h40, 6'd1, pat(32'h4040_1111));
        expect_line(8'h40, pat(32'h4040_AAAA), pat(32'h4040_1111));
        idle(5);

        // Clear after h0 stored, then h1, then new h0
        send(8'h20, 6'd0, pat(32'h2020_0000));
        idle(1);
        drive(1'b0, 8'h00, 6'd0, '0, 1'b0, 8'h00, 1'b1, 8'h20);
        send(8'h20, 6'd1, pat(32'h2020_1111));
        idle(4);
        send(8'h20, 6'd0, pat(32'h2020_2222));
        expect_line(8'h20, pat(32'h2020_2222), pat(32'h2020_1111));
        idle(5);

        // Clear on the same edge as the beat's stage-2 update: clear wins
        send(8'h21, 6'd0, pat(32'h2121_0000));
        drive(1'b0, 8'h00, 6'd0, '0, 1'b0, 8'h00, 1'b1, 8'h21);
        send(8'h21, 6'd1, pat(32'h2121_1111));
        idle(4);
        send(8'h21, 6'd0, pat(32'h2121_2222));
        expect_line(8'h21, pat(32'h2121_2222), pat(32'h2121_1111));
        idle(5);

        // Clear of a different tag on the same edge does not disturb this one
        send(8'h22, 6'd0, pat(32'h2222_AAAA));
        drive(1'b0, 8'h00, 6'd0, '0, 1'b0, 8'h00, 1'b1, 8'h23);
        send(8'h22, 6'd1, pat(32'h2222_BBBB));
        expect_line(8'h22, pat(32'h2222_AAAA), pat(32'h2222_BBBB));
        idle(5);

        // Disabled beats are dropped entirely
        @(posedge clock); #1;
        enabled_in = 1'b0;
        send(8'h50, 6'd0, pat(32'h5050_0000));
        send(8'h50, 6'd1, pat(32'h5050_1111));
        idle(1);
        @(posedge clock); #1;
        enabled_in = 1'b1;
        idle(2);
        send(8'h50, 6'd1, pat(32'h5050_3333));
        idle(5);
        ff = pat(32'h5050_4444);
        send(8'h50, 6'd0, ff);
        expect_line(8'h50, ff, pat(32'h5050_3333));
        idle(5);

        // Reset drops a stored half
        send(8'h30, 6'd0, pat(32'h3030_0000));
        idle(3);
        @(posedge clock); #1;
        rst = 1'b1;
        bw_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_idle_outputs("mid_reset_outputs");
        @(posedge clock); #1;
        rst = 1'b0;
        idle(2);
        send(8'h30, 6'd1, pat(32'h3030_1111));
        idle(8);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL lines_outstanding: %0d left, required 0", exp_q.size());
        end
        checks++;
        if (err_q.size() != 0) begin
            failures++;
            $display("FAIL errors_outstanding: %0d left, required 0", err_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
